// File: rtl/mp3_bitreader.sv
// MSB-first bit-field extractor over a synchronous source ROM.
// A 48-bit buffer is refilled one 16-bit word at a time; each accepted request pops 0..16 bits.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 8
`endif

module mp3_bitreader #(
  parameter int DW = `DATA_WIDTH,
  parameter int AW = `ADDRESS_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  input  logic          req_valid,
  input  logic [4:0]    req_nbits,
  output logic          req_ready,
  output logic          bits_valid,
  output logic [15:0]   bits_data,
  output logic [AW+3:0] bit_cnt
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t        state, state_nx;
  logic [47:0]   buffer, buffer_nx, buffer_c;
  logic [5:0]    count, count_nx, count_c;
  logic          pending, pending_nx;
  logic [AW-1:0] addr_nx;
  logic [AW+3:0] bit_cnt_nx;
  logic [4:0]    nbits;
  logic [15:0]   extract;
  logic          accept, fetch;

  always_comb begin
    nbits     = (req_nbits > 5'd16) ? 5'd16 : req_nbits;
    req_ready = (state == RUN) && (count >= 6'd16) && !start;
    accept    = req_valid && req_ready;
    // The word of a pending fetch lands this cycle, so it counts as already buffered.
    fetch     = (state != IDLE) && !start &&
                (({1'b0, count} + (pending ? 7'd16 : 7'd0)) <= 7'd32);
    // A shift of 48 (nbits=0) leaves nothing, giving a zero result.
    extract   = 16'(buffer >> (6'd48 - {1'b0, nbits}));

    buffer_c = accept ? (buffer << nbits) : buffer;
    count_c  = accept ? (count - {1'b0, nbits}) : count;

    buffer_nx  = buffer_c;
    count_nx   = count_c;
    if (pending) begin
      buffer_nx = buffer_c | (48'({rom_data, 32'h0}) >> count_c);
      count_nx  = count_c + 6'd16;
    end
    pending_nx = fetch;
    addr_nx    = fetch ? rom_addr + 1'b1 : rom_addr;
    bit_cnt_nx = accept ? bit_cnt + {{(AW-1){1'b0}}, nbits} : bit_cnt;

    state_nx = state;
    case (state)
      IDLE:    state_nx = IDLE;
      PRIME:   if (count >= 6'd16) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = IDLE;
    endcase

    // Clearing pending here also drops the word a pre-start fetch returns next cycle.
    if (start) begin
      state_nx   = PRIME;
      buffer_nx  = '0;
      count_nx   = '0;
      pending_nx = 1'b0;
      addr_nx    = start_addr;
      bit_cnt_nx = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      buffer     <= '0;
      count      <= '0;
      pending    <= 1'b0;
      rom_addr   <= '0;
      bit_cnt    <= '0;
      bits_valid <= 1'b0;
      bits_data  <= '0;
    end else begin
      state      <= state_nx;
      buffer     <= buffer_nx;
      count      <= count_nx;
      pending    <= pending_nx;
      rom_addr   <= addr_nx;
      bit_cnt    <= bit_cnt_nx;
      bits_valid <= accept;
      if (accept) bits_data <= extract;
    end
  end

endmodule

// File: tb/tb_mp3_bitreader.sv
// Directed bench for mp3_bitreader with a 16-word synchronous ROM model (AW=4).
module tb_mp3_bitreader;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, req_valid;
  logic [AW-1:0] start_addr, rom_addr;
  logic [15:0]   rom_data, bits_data;
  logic [4:0]    req_nbits;
  logic          req_ready, bits_valid;
  logic [AW+3:0] bit_cnt;
  logic [15:0]   mem [16];

  int total = 0;
  int errs  = 0;

  typedef struct {
    logic [4:0]  n;
    logic [15:0] d;
    logic [7:0]  c;
  } vec_t;
  vec_t vecs[10];

  mp3_bitreader #(.DW(16), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .rom_addr(rom_addr), .rom_data(rom_data), .req_valid(req_valid),
    .req_nbits(req_nbits), .req_ready(req_ready), .bits_valid(bits_valid),
    .bits_data(bits_data), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= mem[rom_addr];

  // Buffer underflow must be impossible whenever a request is accepted.
  always @(posedge clk)
    if (rst_n && req_valid && req_ready)
      assert (dut.count >= ((req_nbits > 5'd16) ? 6'd16 : {1'b0, req_nbits}))
        else $error("FAIL underflow: count %0d nbits %0d", dut.count, req_nbits);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic do_req(input string name, input logic [4:0] n,
                        input logic [15:0] d, input logic [7:0] c);
    wait_ready();
    req_valid = 1'b1;
    req_nbits = n;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({name, "_valid"}, {31'b0, bits_valid}, 32'd1);
    check({name, "_data"}, {16'b0, bits_data}, {16'b0, d});
    check({name, "_cnt"}, {24'b0, bit_cnt}, {24'b0, c});
  endtask

  task automatic do_start(input logic [AW-1:0] a);
    @(negedge clk);
    start = 1'b1;
    start_addr = a;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int unsigned i = 4; i < 15; i++) mem[i] = {4{i[3:0]}};
    mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'h9ABC; mem[3] = 16'hDEF0;
    mem[15] = 16'hAAAA;

    vecs[0] = '{5'd4,  16'h0001, 8'd4};
    vecs[1] = '{5'd12, 16'h0234, 8'd16};
    vecs[2] = '{5'd8,  16'h0056, 8'd24};
    vecs[3] = '{5'd0,  16'h0000, 8'd24};
    vecs[4] = '{5'd4,  16'h0007, 8'd28};
    vecs[5] = '{5'd4,  16'h0008, 8'd32};
    vecs[6] = '{5'd20, 16'h9ABC, 8'd48};
    vecs[7] = '{5'd16, 16'hDEF0, 8'd64};
    vecs[8] = '{5'd3,  16'h0002, 8'd67};
    vecs[9] = '{5'd13, 16'h0444, 8'd80};

    // Reset overrides a concurrent start and request.
    rst_n = 1'b0; start = 1'b1; start_addr = 4'd7; req_valid = 1'b1; req_nbits = 5'd16;
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", {28'b0, rom_addr}, 32'd0);
    check("rst_valid", {31'b0, bits_valid}, 32'd0);
    check("rst_data", {16'b0, bits_data}, 32'd0);
    check("rst_cnt", {24'b0, bit_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0; req_valid = 1'b0;
    check("rst_ready", {31'b0, req_ready}, 32'd0);

    // Table: mixed widths, zero-width and an illegal width.
    do_start(4'd0);
    check("start_valid", {31'b0, bits_valid}, 32'd0);
    for (int unsigned i = 0; i < 10; i++)
      do_req($sformatf("vec%0d", i), vecs[i].n, vecs[i].d, vecs[i].c);
    @(posedge clk); #1;
    check("valid_pulse", {31'b0, bits_valid}, 32'd0);

    // Twenty back-to-back 16-bit requests, wrapping through the ROM.
    do_start(4'd0);
    wait_ready();
    req_valid = 1'b1;
    req_nbits = 5'd16;
    for (int unsigned i = 0; i < 20; i++) begin
      check("b2b_ready", {31'b0, req_ready}, 32'd1);
      @(posedge clk); #1;
      check("b2b_valid", {31'b0, bits_valid}, 32'd1);
      check("b2b_data", {16'b0, bits_data}, {16'b0, mem[i % 16]});
      check("b2b_cnt", {24'b0, bit_cnt}, 32'((i + 1) * 16) & 32'hFF);
      @(negedge clk);
    end

    // Restart mid-stream with a fetch in flight and a request competing.
    start = 1'b1;
    start_addr = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    req_valid = 1'b0;
    check("restart_valid", {31'b0, bits_valid}, 32'd0);
    check("restart_cnt", {24'b0, bit_cnt}, 32'd0);
    check("restart_addr", {28'b0, rom_addr}, 32'd2);
    do_req("restart_w0", 5'd16, 16'h9ABC, 8'd16);
    do_req("restart_w1", 5'd16, 16'hDEF0, 8'd32);

    // Address wrap 15 -> 0.
    mem[0] = 16'h5555;
    do_start(4'd15);
    check("wrap_addr15", {28'b0, rom_addr}, 32'd15);
    @(posedge clk); #1;
    check("wrap_addr0", {28'b0, rom_addr}, 32'd0);
    do_req("wrap_w0", 5'd16, 16'hAAAA, 8'd16);
    do_req("wrap_w1", 5'd16, 16'h5555, 8'd32);

    // One-cycle reset mid-RUN.
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b1; req_nbits = 5'd16;
    @(posedge clk); #1;
    check("midrst_addr", {28'b0, rom_addr}, 32'd0);
    check("midrst_valid", {31'b0, bits_valid}, 32'd0);
    check("midrst_data", {16'b0, bits_data}, 32'd0);
    check("midrst_cnt", {24'b0, bit_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      check("midrst_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    mem[0] = 16'h1234;
    do_start(4'd0);
    do_req("after_rst", 5'd16, 16'h1234, 8'd16);

    $display("== %0d vectors applied, %0d miscompares ==", total, errs);
    $finish;
  end
endmodule
